tx_sequencer: RTL and testbench

Controller that drains a block of bytes from the on-chip message memory into the UART transmit engine, one frame at a time. It performs the LOAD / TX_RDY handshake with the transmitter and drives its framing configuration (EIGHT, PEN, OHEL) and bit-period count (BAUD_COUNT), latched per message. It sits between the memory read port and the transmit engine, replacing manual strobing of LOAD.

---
 rtl/uart_pkg.sv | 37 +++
 rtl/tx_sequencer_if.sv | 34 +++
 rtl/tx_sequencer_baud_lut.sv | 29 ++
 rtl/tx_sequencer.sv | 98 +++++++++
 tb/tb_tx_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit sequencer.
// Baud counts assume a 100 MHz system clock.
package uart_pkg;

  localparam int unsigned CLK_HZ = 100_000_000;
  localparam int BAUD_W = 19;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    WAIT_RDY,
    PULSE,
    WAIT_ACK,
    DONE
  } state_t;

  localparam logic [BAUD_W-1:0] BAUD_300    = 19'd333333;
  localparam logic [BAUD_W-1:0] BAUD_1200   = 19'd83333;
  localparam logic [BAUD_W-1:0] BAUD_2400   = 19'd41667;
  localparam logic [BAUD_W-1:0] BAUD_4800   = 19'd20833;
  localparam logic [BAUD_W-1:0] BAUD_9600   = 19'd10417;
  localparam logic [BAUD_W-1:0] BAUD_19200  = 19'd5208;
  localparam logic [BAUD_W-1:0] BAUD_38400  = 19'd2604;
  localparam logic [BAUD_W-1:0] BAUD_57600  = 19'd1736;
  localparam logic [BAUD_W-1:0] BAUD_115200 = 19'd868;
  localparam logic [BAUD_W-1:0] BAUD_230400 = 19'd434;
  localparam logic [BAUD_W-1:0] BAUD_460800 = 19'd217;
  localparam logic [BAUD_W-1:0] BAUD_921600 = 19'd109;

  localparam logic [3:0] DEFAULT_BAUD_SEL = 4'd4;
  localparam logic [BAUD_W-1:0] DEFAULT_BAUD = BAUD_9600;
  localparam logic DEFAULT_EIGHT = 1'b1;
  localparam logic DEFAULT_PEN   = 1'b0;
  localparam logic DEFAULT_OHEL  = 1'b0;

endpackage

// File: rtl/tx_sequencer_if.sv
// Sequencer <-> UART transmit engine link:
// load handshake, data byte, framing and bit period.
interface tx_sequencer_if;
  import uart_pkg::*;

  logic              TX_RDY;
  logic              LOAD;
  logic [7:0]        OUT_PORT;
  logic              EIGHT;
  logic              PEN;
  logic              OHEL;
  logic [BAUD_W-1:0] BAUD_COUNT;

  modport master (
    input  TX_RDY,
    output LOAD,
    output OUT_PORT,
    output EIGHT,
    output PEN,
    output OHEL,
    output BAUD_COUNT
  );

  modport slave (
    output TX_RDY,
    input  LOAD,
    input  OUT_PORT,
    input  EIGHT,
    input  PEN,
    input  OHEL,
    input  BAUD_COUNT
  );

endinterface

// File: rtl/tx_sequencer_baud_lut.sv
// Baud select to clocks-per-bit lookup (combinational).
// Reserved selects fall back to 115200.
module baud_lut
  import uart_pkg::*;
(
  input  logic [3:0]        sel,
  output logic [BAUD_W-1:0] count
);

  always_comb begin
    count = BAUD_115200;
    case (sel)
      4'd0:    count = BAUD_300;
      4'd1:    count = BAUD_1200;
      4'd2:    count = BAUD_2400;
      4'd3:    count = BAUD_4800;
      4'd4:    count = BAUD_9600;
      4'd5:    count = BAUD_19200;
      4'd6:    count = BAUD_38400;
      4'd7:    count = BAUD_57600;
      4'd8:    count = BAUD_115200;
      4'd9:    count = BAUD_230400;
      4'd10:   count = BAUD_460800;
      4'd11:   count = BAUD_921600;
      default: count = BAUD_115200;
    endcase
  end

endmodule

// File: rtl/tx_sequencer.sv
// Drains a block of message memory into the UART transmitter,
// one LOAD/TX_RDY handshake per byte.
module tx_sequencer
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] base_addr,
  input  logic [7:0] length,
  input  logic       cfg_eight,
  input  logic       cfg_pen,
  input  logic       cfg_ohel,
  input  logic [3:0] cfg_baud,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_data,
  tx_sequencer_if.master tx,
  output logic       busy,
  output logic       done
);

  state_t state;
  state_t state_nx;

  logic [7:0]        addr;
  logic [7:0]        remaining;
  logic [BAUD_W-1:0] lut_count;
  logic              accept;
  logic              acked;
  logic              last;

  baud_lut u_lut (
    .sel   (cfg_baud),
    .count (lut_count)
  );

  assign accept   = (state == IDLE) && start;
  assign acked    = (state == WAIT_ACK) && !tx.TX_RDY;
  assign last     = (remaining == 8'd1);
  assign mem_addr = addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start)
        state_nx = (length == 8'd0) ? DONE : FETCH;
      FETCH:    state_nx = CAPTURE;
      CAPTURE:  state_nx = WAIT_RDY;
      WAIT_RDY: if (tx.TX_RDY) state_nx = PULSE;
      PULSE:    state_nx = WAIT_ACK;
      WAIT_ACK: if (!tx.TX_RDY)
        state_nx = last ? DONE : FETCH;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    tx.LOAD = (state == PULSE);
    done    = (state == DONE);
    busy    = (state != IDLE);
  end

  // Config is captured only on an accepted start so a message
  // is framed consistently even if cfg_* moves underneath it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr          <= 8'd0;
      remaining     <= 8'd0;
      tx.OUT_PORT   <= 8'd0;
      tx.EIGHT      <= DEFAULT_EIGHT;
      tx.PEN        <= DEFAULT_PEN;
      tx.OHEL       <= DEFAULT_OHEL;
      tx.BAUD_COUNT <= DEFAULT_BAUD;
    end else begin
      if (accept) begin
        addr          <= base_addr;
        remaining     <= length;
        tx.EIGHT      <= cfg_eight;
        tx.PEN        <= cfg_pen;
        tx.OHEL       <= cfg_ohel;
        tx.BAUD_COUNT <= lut_count;
      end
      if (state == CAPTURE)
        tx.OUT_PORT <= mem_data;
      if (acked) begin
        remaining <= remaining - 8'd1;
        if (!last) addr <= addr + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_tx_sequencer.sv
// Directed bench for tx_sequencer with a memory model and
// a transmitter model that holds TX_RDY low 20 cycles per frame.
module tb_tx_sequencer;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] base_addr = 8'd0;
  logic [7:0] length = 8'd0;
  logic       cfg_eight = 1'b1;
  logic       cfg_pen = 1'b0;
  logic       cfg_ohel = 1'b0;
  logic [3:0] cfg_baud = 4'd4;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       busy;
  logic       done;

  tx_sequencer_if txi();

  tx_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .cfg_eight (cfg_eight),
    .cfg_pen   (cfg_pen),
    .cfg_ohel  (cfg_ohel),
    .cfg_baud  (cfg_baud),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .tx        (txi),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  always @(posedge clk) mem_data <= mem[mem_addr];

  bit         tx_rdy = 1'b1;
  int         tx_cnt = 0;
  bit         prev_load = 1'b0;
  int         cyc = 0;
  int         load_cnt = 0;
  int         done_cnt = 0;
  logic [7:0] got_data [64];
  logic [7:0] got_addr [64];
  int         load_cyc [64];

  assign txi.TX_RDY = tx_rdy;

  always @(negedge clk) begin
    cyc++;
    if (prev_load) begin
      tx_rdy = 1'b0;
      tx_cnt = 20;
    end else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) tx_rdy = 1'b1;
    end
    prev_load = (txi.LOAD === 1'b1);
    if (txi.LOAD === 1'b1) begin
      if (load_cnt < 64) begin
        got_data[load_cnt] = txi.OUT_PORT;
        got_addr[load_cnt] = mem_addr;
        load_cyc[load_cnt] = cyc;
      end
      load_cnt++;
    end
    if (done === 1'b1) done_cnt++;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d",
               name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  baud;
    logic        eight;
    logic        pen;
    logic        ohel;
    logic [18:0] exp_baud;
  } vec_t;

  vec_t vecs [16];

  initial begin
    bit ok;
    int l0;
    int d0;

    vecs[0]  = '{4'd0,  1'b1, 1'b0, 1'b0, 19'd333333};
    vecs[1]  = '{4'd1,  1'b0, 1'b1, 1'b0, 19'd83333};
    vecs[2]  = '{4'd2,  1'b1, 1'b1, 1'b1, 19'd41667};
    vecs[3]  = '{4'd3,  1'b0, 1'b0, 1'b1, 19'd20833};
    vecs[4]  = '{4'd4,  1'b1, 1'b0, 1'b1, 19'd10417};
    vecs[5]  = '{4'd5,  1'b0, 1'b1, 1'b1, 19'd5208};
    vecs[6]  = '{4'd6,  1'b1, 1'b1, 1'b0, 19'd2604};
    vecs[7]  = '{4'd7,  1'b0, 1'b0, 1'b0, 19'd1736};
    vecs[8]  = '{4'd8,  1'b0, 1'b1, 1'b1, 19'd868};
    vecs[9]  = '{4'd9,  1'b1, 1'b0, 1'b0, 19'd434};
    vecs[10] = '{4'd10, 1'b0, 1'b1, 1'b0, 19'd217};
    vecs[11] = '{4'd11, 1'b1, 1'b0, 1'b1, 19'd109};
    vecs[12] = '{4'd12, 1'b0, 1'b0, 1'b1, 19'd868};
    vecs[13] = '{4'd13, 1'b1, 1'b1, 1'b1, 19'd868};
    vecs[14] = '{4'd14, 1'b0, 1'b1, 1'b0, 19'd868};
    vecs[15] = '{4'd15, 1'b1, 1'b0, 1'b0, 19'd868};

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h41;
    mem[8'h11] = 8'h42;
    mem[8'h12] = 8'h43;
    mem[8'hFE] = 8'hA0;
    mem[8'hFF] = 8'hA1;
    mem[8'h00] = 8'hA2;
    mem[8'h20] = 8'h51;
    mem[8'h21] = 8'h52;
    mem[8'h22] = 8'h53;
    mem[8'h23] = 8'h54;

    // reset state and quiet idle
    tick(3);
    reset = 1'b0;
    tick();
    check("rst_load", txi.LOAD, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_out_port", txi.OUT_PORT, 0);
    check("rst_eight", txi.EIGHT, 1);
    check("rst_pen", txi.PEN, 0);
    check("rst_ohel", txi.OHEL, 0);
    check("rst_baud", txi.BAUD_COUNT, 10417);
    tick(1000);
    check("idle_loads", load_cnt, 0);
    check("idle_busy", busy, 0);

    // baud table and framing via zero-length messages
    l0 = load_cnt;
    for (int i = 0; i < 16; i++) begin
      base_addr = 8'h33;
      length    = 8'd0;
      cfg_baud  = vecs[i].baud;
      cfg_eight = vecs[i].eight;
      cfg_pen   = vecs[i].pen;
      cfg_ohel  = vecs[i].ohel;
      pulse_start();
      check($sformatf("v%0d_done", i), done, 1);
      check($sformatf("v%0d_busy", i), busy, 1);
      check($sformatf("v%0d_baud", i),
            txi.BAUD_COUNT, vecs[i].exp_baud);
      check($sformatf("v%0d_eight", i), txi.EIGHT, vecs[i].eight);
      check($sformatf("v%0d_pen", i), txi.PEN, vecs[i].pen);
      check($sformatf("v%0d_ohel", i), txi.OHEL, vecs[i].ohel);
      tick();
      check($sformatf("v%0d_done_off", i), done, 0);
      check($sformatf("v%0d_busy_off", i), busy, 0);
    end
    check("len0_loads", load_cnt - l0, 0);

    // three-byte message with latency, stability and ignores
    tick(2);
    l0 = load_cnt;
    d0 = done_cnt;
    base_addr = 8'h10;
    length    = 8'd3;
    cfg_baud  = 4'd8;
    cfg_eight = 1'b0;
    cfg_pen   = 1'b1;
    cfg_ohel  = 1'b1;
    pulse_start();
    check("m_busy_n1", busy, 1);
    check("m_baud_n1", txi.BAUD_COUNT, 868);
    check("m_eight_n1", txi.EIGHT, 0);
    check("m_pen_n1", txi.PEN, 1);
    check("m_ohel_n1", txi.OHEL, 1);
    check("m_fetch_addr", mem_addr, 8'h10);
    cfg_baud  = 4'd0;
    cfg_eight = 1'b1;
    cfg_pen   = 1'b0;
    cfg_ohel  = 1'b0;
    base_addr = 8'h99;
    length    = 8'd7;
    tick(2);
    check("m_load_n3", txi.LOAD, 0);
    check("m_outport_n3", txi.OUT_PORT, 8'h41);
    tick();
    check("m_load_n4", txi.LOAD, 1);
    tick(5);
    pulse_start();
    wait_done(400, ok);
    check("m_done_seen", ok, 1);
    check("m_loads", load_cnt - l0, 3);
    check("m_byte0", got_data[l0], 8'h41);
    check("m_byte1", got_data[l0 + 1], 8'h42);
    check("m_byte2", got_data[l0 + 2], 8'h43);
    check("m_gap", load_cyc[l0 + 1] - load_cyc[l0], 22);
    check("m_baud_hold", txi.BAUD_COUNT, 868);
    check("m_eight_hold", txi.EIGHT, 0);
    check("m_pen_hold", txi.PEN, 1);
    check("m_ohel_hold", txi.OHEL, 1);
    pulse_start();
    check("m_busy_after", busy, 0);
    check("m_done_after", done, 0);
    tick();
    check("m_start_at_done", busy, 0);
    tick(30);
    check("m_done_cnt", done_cnt - d0, 1);
    check("m_loads_final", load_cnt - l0, 3);

    // address wrap past 0xFF
    l0 = load_cnt;
    base_addr = 8'hFE;
    length    = 8'd3;
    cfg_baud  = 4'd5;
    pulse_start();
    check("w_baud", txi.BAUD_COUNT, 5208);
    wait_done(400, ok);
    check("w_done_seen", ok, 1);
    check("w_loads", load_cnt - l0, 3);
    check("w_addr0", got_addr[l0], 8'hFE);
    check("w_addr1", got_addr[l0 + 1], 8'hFF);
    check("w_addr2", got_addr[l0 + 2], 8'h00);
    check("w_byte0", got_data[l0], 8'hA0);
    check("w_byte1", got_data[l0 + 1], 8'hA1);
    check("w_byte2", got_data[l0 + 2], 8'hA2);
    tick(30);

    // reset while waiting for the ack of byte 2 of 4
    l0 = load_cnt;
    base_addr = 8'h20;
    length    = 8'd4;
    cfg_baud  = 4'd2;
    pulse_start();
    for (int i = 0; i < 200; i++) begin
      if (load_cnt - l0 == 2) break;
      tick();
    end
    check("r_reach_byte2", load_cnt - l0, 2);
    check("r_wait_ack_load", txi.LOAD, 0);
    check("r_wait_ack_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check("r_async_busy", busy, 0);
    check("r_async_load", txi.LOAD, 0);
    check("r_async_done", done, 0);
    check("r_async_baud", txi.BAUD_COUNT, 10417);
    check("r_async_outport", txi.OUT_PORT, 0);
    check("r_async_mem_addr", mem_addr, 0);
    check("r_async_eight", txi.EIGHT, 1);
    tick(3);
    reset = 1'b0;
    tick(60);
    check("r_no_more_loads", load_cnt - l0, 2);
    check("r_idle_busy", busy, 0);
    l0 = load_cnt;
    pulse_start();
    wait_done(600, ok);
    check("r_done_seen", ok, 1);
    check("r_loads", load_cnt - l0, 4);
    check("r_byte0", got_data[l0], 8'h51);
    check("r_byte1", got_data[l0 + 1], 8'h52);
    check("r_byte2", got_data[l0 + 2], 8'h53);
    check("r_byte3", got_data[l0 + 3], 8'h54);
    check("r_addr0", got_addr[l0], 8'h20);
    check("r_addr3", got_addr[l0 + 3], 8'h23);
    tick(5);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
